// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into 16-bit ISA words and streams them, with
// their write addresses, through a small FIFO toward instruction memory.
module instruction_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_pi,
  input  logic              reset_n_pi,
  input  logic              op_valid_pi,
  output logic              op_ready_po,
  input  logic [3:0]        opcode_pi,
  input  logic [2:0]        alu_func_pi,
  input  logic [2:0]        dest_reg_pi,
  input  logic [2:0]        src_reg1_pi,
  input  logic [2:0]        src_reg2_pi,
  input  logic [11:0]       imm_pi,
  input  logic              movi_high_pi,
  input  logic [1:0]        ctrl_cmd_pi,
  input  logic              addr_load_pi,
  input  logic [ADDR_W-1:0] addr_pi,
  output logic              instr_valid_po,
  input  logic              instr_ready_pi,
  output logic [15:0]       instr_po,
  output logic [ADDR_W-1:0] instr_addr_po,
  output logic              err_po,
  output logic [1:0]        err_code_po,
  output logic              sealed_po
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic {ST_RUN, ST_SEALED} state_e;

  state_e            state_q, state_d;
  logic [15:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [15:0] word_d;
  logic        illegal_op, range_err, imm6_ok, is_halt;
  logic        accept, reject, push, pop, load_ok;

  assign imm6_ok = (imm_pi[11:5] == 7'h00) || (imm_pi[11:5] == 7'h7F);
  assign is_halt = (opcode_pi == 4'hF) && (ctrl_cmd_pi == 2'd3);

  always_comb begin
    word_d     = 16'h0000;
    illegal_op = 1'b0;
    range_err  = 1'b0;
    case (opcode_pi)
      4'h0: word_d = 16'h0000;
      4'h1, 4'h2: word_d = {opcode_pi, dest_reg_pi, src_reg1_pi, src_reg2_pi, alu_func_pi};
      4'h3: begin
        word_d    = {opcode_pi, dest_reg_pi, movi_high_pi, imm_pi[7:0]};
        range_err = (imm_pi[11:8] != 4'h0);
      end
      4'h4, 4'h5, 4'h6, 4'h7: begin
        word_d    = {opcode_pi, dest_reg_pi, src_reg1_pi, imm_pi[5:0]};
        range_err = !imm6_ok;
      end
      4'h8, 4'h9, 4'hA: begin
        word_d    = {opcode_pi, src_reg1_pi, src_reg2_pi, imm_pi[5:0]};
        range_err = !imm6_ok;
      end
      4'hB, 4'hC: word_d = {opcode_pi, imm_pi};
      4'hF: begin
        case (ctrl_cmd_pi)
          2'd0:    word_d = 16'hF001;
          2'd1:    word_d = 16'hF002;
          2'd2:    word_d = 16'hFAAA;
          default: word_d = 16'hFFFF;
        endcase
      end
      default: illegal_op = 1'b1;
    endcase
  end

  // Handshakes, FIFO bookkeeping and the RUN/SEALED next-state logic.
  always_comb begin
    op_ready_po = (state_q == ST_SEALED) ? 1'b1 : (count_q != FULL_CNT);
    accept      = op_valid_pi && op_ready_po;
    reject      = accept && ((state_q == ST_SEALED) || illegal_op || range_err);
    push        = accept && !reject;
    pop         = instr_valid_po && instr_ready_pi;
    load_ok     = addr_load_pi && (count_q == '0);

    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    err_d      = reject;
    err_code_d = err_code_q;

    if (reject) begin
      if (state_q == ST_SEALED) err_code_d = 2'd3;
      else if (illegal_op)      err_code_d = 2'd1;
      else                      err_code_d = 2'd2;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;

    if (load_ok)  addr_d = addr_pi;
    else if (pop) addr_d = addr_q + ADDR_ONE;

    case (state_q)
      ST_RUN:    if (push && is_halt) state_d = ST_SEALED;
      ST_SEALED: if (load_ok)         state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (!reset_n_pi) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= BASE_ADDR;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Storage needs no reset: the count gates everything read out of it.
  always_ff @(posedge clk_pi) begin
    if (push) mem_q[wr_ptr_q] <= word_d;
  end

  assign instr_valid_po = (count_q != '0);
  assign instr_po       = instr_valid_po ? mem_q[rd_ptr_q] : 16'h0000;
  assign instr_addr_po  = addr_q;
  assign err_po         = err_q;
  assign err_code_po    = err_code_q;
  assign sealed_po      = (state_q == ST_SEALED);

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench for instruction_encoder with hand-computed expected words,
// addresses and error codes.
module tb_instruction_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetN, opValid, opReady, moviHigh, addrLoad;
  logic [3:0]  opcode;
  logic [2:0]  aluFunc, destReg, srcReg1, srcReg2;
  logic [11:0] imm;
  logic [1:0]  ctrlCmd, errCode;
  logic [7:0]  addr, instrAddr;
  logic        instrValid, instrReady, err, sealed;
  logic [15:0] instr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(8'h00)) dut (
    .clk_pi(clk), .reset_n_pi(resetN), .op_valid_pi(opValid), .op_ready_po(opReady),
    .opcode_pi(opcode), .alu_func_pi(aluFunc), .dest_reg_pi(destReg),
    .src_reg1_pi(srcReg1), .src_reg2_pi(srcReg2), .imm_pi(imm),
    .movi_high_pi(moviHigh), .ctrl_cmd_pi(ctrlCmd), .addr_load_pi(addrLoad),
    .addr_pi(addr), .instr_valid_po(instrValid), .instr_ready_pi(instrReady),
    .instr_po(instr), .instr_addr_po(instrAddr), .err_po(err),
    .err_code_po(errCode), .sealed_po(sealed)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1,
                          input logic [2:0] s2, input logic [2:0] f, input logic [11:0] im,
                          input logic hi, input logic [1:0] cc);
    opcode = op; destReg = d; srcReg1 = s1; srcReg2 = s2; aluFunc = f;
    imm = im; moviHigh = hi; ctrlCmd = cc; opValid = 1'b1;
    tick();
    opValid = 1'b0;
  endtask

  task automatic pop_one;
    instrReady = 1'b1;
    tick();
    instrReady = 1'b0;
  endtask

  task automatic load_addr(input logic [7:0] a);
    addrLoad = 1'b1;
    addr = a;
    tick();
    addrLoad = 1'b0;
  endtask

  task automatic test_reset;
    resetN = 1'b0; opValid = 1'b0; instrReady = 1'b0; addrLoad = 1'b0; addr = 8'h00;
    opcode = 4'h0; destReg = 3'd0; srcReg1 = 3'd0; srcReg2 = 3'd0; aluFunc = 3'd0;
    imm = 12'h000; moviHigh = 1'b0; ctrlCmd = 2'd0;
    tick(); tick();
    vectors++; if (opReady !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_ready got %b want 1", opReady); end
    vectors++; if (instrValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid got %b want 0", instrValid); end
    vectors++; if (instr !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_instr got %h want 0000", instr); end
    vectors++; if (instrAddr !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_addr got %h want 00", instrAddr); end
    vectors++; if ({err, errCode, sealed} !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_flags got %b want 0000", {err, errCode, sealed}); end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_arith;
    drive_op(4'h1, 3'd1, 3'd2, 3'd3, 3'd0, 12'h000, 1'b0, 2'd0);
    vectors++; if (instrValid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_valid got %b want 1", instrValid); end
    vectors++; if (instr !== 16'h1298) begin miscompares++; $display("[TB] FAIL add_word got %h want 1298", instr); end
    vectors++; if (instrAddr !== 8'h00) begin miscompares++; $display("[TB] FAIL add_addr got %h want 00", instrAddr); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL add_err got %b want 0", err); end
    pop_one();
    vectors++; if (instrValid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_pop_valid got %b want 0", instrValid); end
    vectors++; if (instrAddr !== 8'h01) begin miscompares++; $display("[TB] FAIL add_pop_addr got %h want 01", instrAddr); end
  endtask

  task automatic test_movi;
    drive_op(4'h3, 3'd4, 3'd0, 3'd0, 3'd0, 12'h05A, 1'b1, 2'd0);
    vectors++; if (instr !== 16'h395A) begin miscompares++; $display("[TB] FAIL movi_word got %h want 395A", instr); end
    vectors++; if (instrAddr !== 8'h01) begin miscompares++; $display("[TB] FAIL movi_addr got %h want 01", instrAddr); end
    pop_one();
    drive_op(4'h3, 3'd4, 3'd0, 3'd0, 3'd0, 12'h15A, 1'b1, 2'd0);
    vectors++; if ({err, errCode} !== 3'b110) begin miscompares++; $display("[TB] FAIL movi_range got err=%b code=%0d want err=1 code=2", err, errCode); end
    vectors++; if (instrValid !== 1'b0) begin miscompares++; $display("[TB] FAIL movi_range_nowrite got %b want 0", instrValid); end
    tick();
    vectors++; if ({err, errCode} !== 3'b010) begin miscompares++; $display("[TB] FAIL err_hold got err=%b code=%0d want err=0 code=2", err, errCode); end
  endtask

  task automatic test_branch_and_errors;
    drive_op(4'h8, 3'd0, 3'd1, 3'd1, 3'd0, 12'hFFF, 1'b0, 2'd0);
    vectors++; if (instr !== 16'h827F) begin miscompares++; $display("[TB] FAIL beq_word got %h want 827F", instr); end
    vectors++; if (instrAddr !== 8'h02) begin miscompares++; $display("[TB] FAIL beq_addr got %h want 02", instrAddr); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL beq_err got %b want 0", err); end
    pop_one();
    drive_op(4'h4, 3'd1, 3'd2, 3'd0, 3'd0, 12'h020, 1'b0, 2'd0);
    vectors++; if ({err, errCode, instrValid} !== 4'b1100) begin miscompares++; $display("[TB] FAIL addi_range got %b want 1100", {err, errCode, instrValid}); end
    tick();
    drive_op(4'hD, 3'd1, 3'd2, 3'd3, 3'd0, 12'h000, 1'b0, 2'd0);
    vectors++; if ({err, errCode, instrValid} !== 4'b1010) begin miscompares++; $display("[TB] FAIL illegal_op got %b want 1010", {err, errCode, instrValid}); end
    tick();
    drive_op(4'h4, 3'd1, 3'd2, 3'd0, 3'd0, 12'hFE0, 1'b0, 2'd0);
    vectors++; if (instr !== 16'h42A0) begin miscompares++; $display("[TB] FAIL addi_neg got %h want 42A0", instr); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL addi_neg_err got %b want 0", err); end
    pop_one();
    drive_op(4'hC, 3'd0, 3'd0, 3'd0, 3'd0, 12'hABC, 1'b0, 2'd0);
    vectors++; if (instr !== 16'hCABC) begin miscompares++; $display("[TB] FAIL jump_word got %h want CABC", instr); end
    pop_one();
    drive_op(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 12'h000, 1'b0, 2'd0);
    vectors++; if (instr !== 16'hF001) begin miscompares++; $display("[TB] FAIL stc_word got %h want F001", instr); end
    pop_one();
    drive_op(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 12'h000, 1'b0, 2'd2);
    vectors++; if (instr !== 16'hFAAA) begin miscompares++; $display("[TB] FAIL ctrl_reset_word got %h want FAAA", instr); end
    vectors++; if (instrAddr !== 8'h06) begin miscompares++; $display("[TB] FAIL ctrl_reset_addr got %h want 06", instrAddr); end
    pop_one();
  endtask

  task automatic test_full;
    logic [15:0] expWord;
    load_addr(8'h00);
    vectors++; if (instrAddr !== 8'h00) begin miscompares++; $display("[TB] FAIL load_addr got %h want 00", instrAddr); end
    for (int i = 0; i < DEPTH; i++) drive_op(4'hC, 3'd0, 3'd0, 3'd0, 3'd0, 12'(i), 1'b0, 2'd0);
    vectors++; if (opReady !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready got %b want 0", opReady); end
    drive_op(4'hC, 3'd0, 3'd0, 3'd0, 3'd0, 12'h0FF, 1'b0, 2'd0);
    instrReady = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      expWord = 16'hC000 | 16'(i);
      vectors++; if (instr !== expWord || instrAddr !== 8'(i)) begin miscompares++; $display("[TB] FAIL full_drain%0d got %h@%h want %h@%h", i, instr, instrAddr, expWord, 8'(i)); end
      tick();
    end
    instrReady = 1'b0;
    vectors++; if (instrValid !== 1'b0) begin miscompares++; $display("[TB] FAIL full_empty got %b want 0", instrValid); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] expWord;
    load_addr(8'h20);
    instrReady = 1'b1;
    opcode = 4'hC; destReg = 3'd0; srcReg1 = 3'd0; srcReg2 = 3'd0; aluFunc = 3'd0;
    moviHigh = 1'b0; ctrlCmd = 2'd0; opValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imm = 12'h100 + 12'(i);
      tick();
      expWord = 16'hC100 + 16'(i);
      vectors++; if (instrValid !== 1'b1 || instr !== expWord || instrAddr !== 8'(8'h20 + i)) begin miscompares++; $display("[TB] FAIL b2b%0d got v=%b %h@%h want %h@%h", i, instrValid, instr, instrAddr, expWord, 8'(8'h20 + i)); end
    end
    opValid = 1'b0;
    tick();
    instrReady = 1'b0;
    vectors++; if (instrValid !== 1'b0 || instrAddr !== 8'h24) begin miscompares++; $display("[TB] FAIL b2b_end got v=%b @%h want v=0 @24", instrValid, instrAddr); end
  endtask

  task automatic test_addr_wrap;
    load_addr(8'hFF);
    drive_op(4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 12'h000, 1'b0, 2'd0);
    drive_op(4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 12'h000, 1'b0, 2'd0);
    vectors++; if (instrValid !== 1'b1 || instr !== 16'h0000 || instrAddr !== 8'hFF) begin miscompares++; $display("[TB] FAIL wrap_first got v=%b %h@%h want 0000@FF", instrValid, instr, instrAddr); end
    pop_one();
    vectors++; if (instrValid !== 1'b1 || instrAddr !== 8'h00) begin miscompares++; $display("[TB] FAIL wrap_second got v=%b @%h want v=1 @00", instrValid, instrAddr); end
    load_addr(8'h40);
    vectors++; if (instrAddr !== 8'h00) begin miscompares++; $display("[TB] FAIL load_ignored got %h want 00", instrAddr); end
    pop_one();
    vectors++; if (instrValid !== 1'b0 || instrAddr !== 8'h01) begin miscompares++; $display("[TB] FAIL wrap_end got v=%b @%h want v=0 @01", instrValid, instrAddr); end
  endtask

  task automatic test_halt;
    drive_op(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 12'h000, 1'b0, 2'd3);
    vectors++; if (instr !== 16'hFFFF || sealed !== 1'b1 || opReady !== 1'b1) begin miscompares++; $display("[TB] FAIL halt got %h sealed=%b rdy=%b want FFFF 1 1", instr, sealed, opReady); end
    drive_op(4'h1, 3'd1, 3'd2, 3'd3, 3'd0, 12'h000, 1'b0, 2'd0);
    vectors++; if ({err, errCode} !== 3'b111) begin miscompares++; $display("[TB] FAIL sealed_err got err=%b code=%0d want err=1 code=3", err, errCode); end
    vectors++; if (instr !== 16'hFFFF || instrAddr !== 8'h01) begin miscompares++; $display("[TB] FAIL sealed_fifo got %h@%h want FFFF@01", instr, instrAddr); end
    load_addr(8'h10);
    vectors++; if (sealed !== 1'b1) begin miscompares++; $display("[TB] FAIL sealed_load_busy got %b want 1", sealed); end
    pop_one();
    vectors++; if (instrValid !== 1'b0 || sealed !== 1'b1 || instrAddr !== 8'h02) begin miscompares++; $display("[TB] FAIL halt_drain got v=%b s=%b @%h want 0 1 @02", instrValid, sealed, instrAddr); end
    load_addr(8'h10);
    vectors++; if (sealed !== 1'b0 || instrAddr !== 8'h10) begin miscompares++; $display("[TB] FAIL unseal got s=%b @%h want 0 @10", sealed, instrAddr); end
    drive_op(4'h1, 3'd1, 3'd2, 3'd3, 3'd0, 12'h000, 1'b0, 2'd0);
    vectors++; if (instr !== 16'h1298 || instrAddr !== 8'h10 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL after_unseal got %h@%h err=%b want 1298@10 0", instr, instrAddr, err); end
  endtask

  task automatic test_reset_mid;
    drive_op(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 12'h000, 1'b0, 2'd3);
    vectors++; if (sealed !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_sealed got %b want 1", sealed); end
    resetN = 1'b0;
    tick();
    vectors++; if (instrValid !== 1'b0 || instr !== 16'h0000 || instrAddr !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_reset got v=%b %h@%h want 0 0000@00", instrValid, instr, instrAddr); end
    vectors++; if (sealed !== 1'b0 || opReady !== 1'b1 || errCode !== 2'd0) begin miscompares++; $display("[TB] FAIL mid_reset_flags got s=%b r=%b c=%0d want 0 1 0", sealed, opReady, errCode); end
    resetN = 1'b1;
    tick();
    drive_op(4'h1, 3'd1, 3'd2, 3'd3, 3'd0, 12'h000, 1'b0, 2'd0);
    vectors++; if (instr !== 16'h1298 || instrAddr !== 8'h00) begin miscompares++; $display("[TB] FAIL post_reset got %h@%h want 1298@00", instr, instrAddr); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_movi();
    test_branch_and_errors();
    test_full();
    test_back_to_back();
    test_addr_wrap();
    test_halt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
